// File: rtl/com_tx_fifo.sv
// Word FIFO capturing COM loads from data RAM, serialised LSB byte first onto an
// 8-bit bus with a DIV-cycle-per-phase strobe and host ready handshake.
module com_tx_fifo #(
  parameter  int DEPTH = 16,
  parameter  int DIV   = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          com_flag,
  input  logic          mem_to_reg,
  input  logic [31:0]   read_data,
  input  logic          ext_ready,
  output logic          clk_out,
  output logic [7:0]    data_out,
  output logic          busy,
  output logic [CW-1:0] level,
  output logic          full,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] PH_LAST  = DW'(DIV - 1);
  localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_HIGH, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   level_q;
  logic            ovf_q;
  logic [31:0]     shreg_q;
  logic [1:0]      bidx_q;
  logic [DW-1:0]   cnt_q;
  logic            clk_out_q;

  logic push, pop, push_ok, phase_end, shift;

  assign push      = com_flag & mem_to_reg;
  assign pop       = (state_q == S_LOAD);
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push_ok   = push & (~full | pop);
  assign phase_end = (cnt_q == PH_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    shift   = 1'b0;
    case (state_q)
      S_IDLE:  if (level_q != '0 && ext_ready) state_d = S_LOAD;
      S_LOAD:  state_d = S_SETUP;
      S_SETUP: if (phase_end) state_d = S_HIGH;
      S_HIGH: begin
        if (phase_end) begin
          if (bidx_q == 2'd3) begin
            state_d = S_IDLE;
          end else if (ext_ready) begin
            state_d = S_SETUP;
            shift   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (ext_ready) begin
          state_d = S_SETUP;
          shift   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    clk_out  = clk_out_q;
    data_out = shreg_q[7:0];
    level    = level_q;
    full     = (level_q == LVL_FULL);
    overflow = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= read_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      shreg_q   <= '0;
      bidx_q    <= 2'd0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (!push_ok && pop) level_q <= level_q - 1'b1;
      if (push && !push_ok) ovf_q <= 1'b1;
      if (pop) begin
        shreg_q <= mem_q[rd_ptr_q];
        bidx_q  <= 2'd0;
      end else if (shift) begin
        shreg_q <= {8'h00, shreg_q[31:8]};
        bidx_q  <= bidx_q + 2'd1;
      end
      // Phase counter restarts on every state change so each phase is exactly DIV cycles.
      if ((state_q == S_SETUP || state_q == S_HIGH) && !phase_end) cnt_q <= cnt_q + 1'b1;
      else                                                          cnt_q <= '0;
      clk_out_q <= (state_d == S_HIGH);
    end
  end

endmodule
